// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter sharing one APB master port
// among NUM_REQ requesters, with psel decode and ACCESS-phase timeout.
//
// Ports:
//   pclk, preset          clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready one-hot, IDLE only)
//   req_addr/write/wdata  flattened per-requester transfer fields
//   rsp_valid             one-cycle completion pulse to the served requester
//   rsp_rdata/rsp_err     response data/error, held between pulses
//   paddr..pwdata         APB master outputs
//   pready/prdata/pslverr APB slave responses (used in ACCESS only)
module apb_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PSEL_WIDTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          pwrite,
    output logic [PSEL_WIDTH-1:0]         psel,
    output logic                          penable,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic                          pready,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pslverr
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SB = (PSEL_WIDTH > 1) ? $clog2(PSEL_WIDTH) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]            r_state;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CW-1:0]         r_cnt;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    int                    w_idx;
    logic [IW-1:0]         w_idx_t;
    logic                  w_found;
    logic [IW-1:0]         w_winner;
    logic                  w_grant;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_write;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [PSEL_WIDTH-1:0] w_sel;
    logic                  w_active;
    logic                  w_timeout;
    logic                  w_done;

    // Scan from the pointer upward with wrap; first valid wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        w_idx_t  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_idx_t = IW'(w_idx);
            if (!w_found && req_valid[w_idx_t]) begin
                w_found  = 1'b1;
                w_winner = w_idx_t;
            end
        end
    end

    // No grant while reset is asserted, so nothing is consumed then.
    assign w_grant = (r_state == S_IDLE) && w_found && !preset;

    always_comb begin
        req_ready = '0;
        w_addr    = '0;
        w_write   = 1'b0;
        w_wdata   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IW'(i)) begin
                req_ready[i] = w_grant;
                w_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_write = req_write[i];
                w_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    generate
        if (PSEL_WIDTH == 1) begin : g_psel1
            assign w_sel = 1'b1;
        end else begin : g_pseln
            always_comb begin
                w_sel = '0;
                w_sel[r_addr[ADDR_WIDTH-1 -: SB]] = 1'b1;
            end
        end
    endgenerate

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
    assign w_done    = pready || w_timeout;
    assign w_active  = (r_state == S_SETUP) || (r_state == S_ACCESS);

    assign psel      = w_active ? w_sel : '0;
    assign penable   = (r_state == S_ACCESS);
    assign paddr     = w_active ? r_addr : '0;
    assign pwrite    = w_active && r_write;
    assign pwdata    = w_active ? r_wdata : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_id    <= w_winner;
                        r_addr  <= w_addr;
                        r_write <= w_write;
                        r_wdata <= w_wdata;
                        if (w_winner == IW'(NUM_REQ - 1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= w_winner + 1'b1;
                        end
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt   <= CW'(1);
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_done) begin
                        r_rsp_valid[r_id] <= 1'b1;
                        // Timeout and writes both return zero data.
                        r_rsp_rdata <= (pready && !r_write) ? prdata : '0;
                        r_rsp_err   <= pready ? pslverr : 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed bench
// NUM_REQ=4, AW=DW=32, PSEL_WIDTH=4, TIMEOUT=16
module tb_apb_master_arbiter;

  logic         pclk;
  logic         preset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_addr;
  logic [3:0]   req_write;
  logic [127:0] req_wdata;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [31:0]  paddr;
  logic         pwrite;
  logic [3:0]   psel;
  logic         penable;
  logic [31:0]  pwdata;
  logic         pready;
  logic [31:0]  prdata;
  logic         pslverr;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(32),
    .DATA_WIDTH(32), .PSEL_WIDTH(4),
    .TIMEOUT(16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite),
    .psel(psel), .penable(penable),
    .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: obs %0h exp %0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_req(
    input int i, input logic [31:0] a,
    input logic w, input logic [31:0] d);
    req_addr[i*32 +: 32]  = a;
    req_write[i]          = w;
    req_wdata[i*32 +: 32] = d;
  endtask

  initial begin
    logic [3:0] exp_oh;
    int g;
    int gorder [5] = '{0, 1, 2, 3, 0};

    preset    = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    tick();
    tick();

    chk("rst_psel", psel, 4'b0000);
    chk("rst_penable", penable, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", rsp_err, 1'b0);

    preset = 1'b0;
    set_req(0, 32'h0000_0010, 1'b1,
            32'hA5A5_A5A5);
    req_valid = 4'b0001;
    pready = 1'b1;
    #1;
    chk("t1_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t1_setup_psel", psel, 4'b0001);
    chk("t1_setup_pen", penable, 1'b0);
    chk("t1_setup_paddr", paddr,
        32'h0000_0010);
    chk("t1_setup_pwrite", pwrite, 1'b1);
    chk("t1_setup_pwdata", pwdata,
        32'hA5A5_A5A5);
    tick();
    chk("t1_acc_psel", psel, 4'b0001);
    chk("t1_acc_pen", penable, 1'b1);
    chk("t1_acc_rspv", rsp_valid, 4'b0000);
    tick();
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_rsp_rdata", rsp_rdata, 32'h0);
    chk("t1_idle_psel", psel, 4'b0000);
    chk("t1_idle_pen", penable, 1'b0);
    chk("t1_idle_paddr", paddr, 32'h0);
    chk("t1_idle_pwdata", pwdata, 32'h0);

    set_req(2, 32'h4000_0004, 1'b0, 32'h0);
    req_valid = 4'b0100;
    pready = 1'b0;
    #1;
    chk("t2_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t2_setup_psel", psel, 4'b0010);
    chk("t2_setup_paddr", paddr,
        32'h4000_0004);
    chk("t2_setup_pwrite", pwrite, 1'b0);
    chk("t2_rspv_clear", rsp_valid, 4'b0000);
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("t2_acc_pen", penable, 1'b1);
      chk("t2_acc_psel", psel, 4'b0010);
      chk("t2_acc_rspv", rsp_valid, 4'b0000);
      if (c == 4) begin
        pready = 1'b1;
        prdata = 32'h1234_5678;
      end
      tick();
    end
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    #1;
    chk("t2_rsp_valid", rsp_valid, 4'b0100);
    chk("t2_rsp_rdata", rsp_rdata,
        32'h1234_5678);
    chk("t2_rsp_err", rsp_err, 1'b0);
    chk("t2_idle_pen", penable, 1'b0);

    preset = 1'b1;
    tick();
    preset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(i, {i[1:0], 30'h100} + 32'(i),
              1'b0, 32'h0);
    end
    req_valid = 4'b1111;
    pready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = gorder[k];
      exp_oh = 4'b0001 << g;
      #1;
      chk("t3_grant", req_ready, exp_oh);
      tick();
      chk("t3_setup_psel", psel, exp_oh);
      chk("t3_setup_paddr", paddr,
          {g[1:0], 30'h100} + 32'(g));
      tick();
      prdata = 32'h1000 + 32'(g);
      tick();
      chk("t3_rsp_valid", rsp_valid, exp_oh);
      chk("t3_rsp_rdata", rsp_rdata,
          32'h1000 + 32'(g));
    end
    req_valid = 4'b0000;
    pready = 1'b0;

    set_req(1, 32'hC000_0008, 1'b0, 32'h0);
    prdata = 32'hDEAD_BEEF;
    req_valid = 4'b0010;
    #1;
    chk("t4_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t4_setup_psel", psel, 4'b1000);
    tick();
    for (int c = 1; c <= 16; c++) begin
      chk("t4_acc_pen", penable, 1'b1);
      chk("t4_acc_rspv", rsp_valid, 4'b0000);
      tick();
    end
    chk("t4_rsp_valid", rsp_valid, 4'b0010);
    chk("t4_rsp_err", rsp_err, 1'b1);
    chk("t4_rsp_rdata", rsp_rdata, 32'h0);
    chk("t4_rel_psel", psel, 4'b0000);
    chk("t4_rel_pen", penable, 1'b0);

    set_req(3, 32'h8000_0000, 1'b1,
            32'h0000_0055);
    req_valid = 4'b1000;
    pready = 1'b1;
    pslverr = 1'b1;
    #1;
    chk("t5_grant", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t5_setup_psel", psel, 4'b0100);
    chk("t5_setup_pwrite", pwrite, 1'b1);
    chk("t5_setup_pwdata", pwdata,
        32'h0000_0055);
    tick();
    tick();
    chk("t5_rsp_valid", rsp_valid, 4'b1000);
    chk("t5_rsp_err", rsp_err, 1'b1);
    chk("t5_rsp_rdata", rsp_rdata, 32'h0);
    pslverr = 1'b0;
    set_req(0, 32'h0000_0010, 1'b0, 32'h0);
    prdata = 32'hCAFE_0001;
    req_valid = 4'b0001;
    #1;
    chk("t5b_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    chk("t5b_rsp_valid", rsp_valid, 4'b0001);
    chk("t5b_rsp_err", rsp_err, 1'b0);
    chk("t5b_rsp_rdata", rsp_rdata,
        32'hCAFE_0001);
    prdata = 32'h0BAD_0BAD;
    tick();
    chk("t5b_hold_rspv", rsp_valid, 4'b0000);
    chk("t5b_hold_rdata", rsp_rdata,
        32'hCAFE_0001);
    chk("t5b_hold_err", rsp_err, 1'b0);

    set_req(2, 32'h4000_0000, 1'b1,
            32'h7777_7777);
    pready = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("t6_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    chk("t6_acc2_pen", penable, 1'b1);
    preset = 1'b1;
    pready = 1'b1;
    tick();
    chk("t6_rst_psel", psel, 4'b0000);
    chk("t6_rst_pen", penable, 1'b0);
    chk("t6_rst_paddr", paddr, 32'h0);
    chk("t6_rst_pwdata", pwdata, 32'h0);
    chk("t6_rst_pwrite", pwrite, 1'b0);
    chk("t6_rst_rspv", rsp_valid, 4'b0000);
    chk("t6_rst_rdata", rsp_rdata, 32'h0);
    chk("t6_rst_ready", req_ready, 4'b0000);
    preset = 1'b0;
    pready = 1'b0;
    tick();
    chk("t6_no_rspv", rsp_valid, 4'b0000);
    req_valid = 4'b1111;
    #1;
    chk("t6_ptr0", req_ready, 4'b0001);
    req_valid = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
